// File: rtl/jk_cmd_debounce.sv
// Button front end for the negedge JK stage: two-flop sync, per-button debounce,
// press-edge detect, and a registered one-cycle {j,k} command encoder.

module jk_cmd_debounce_lane #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic press_o
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic             s1_q, s2_q;
   logic             st_q, st_d;
   logic             st_dly_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any cycle where s2 agrees with the stable value restarts the count,
   // so only an unbroken run of DB_CYCLES disagreeing edges flips st.
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      if (s2_q == st_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         st_d  = s2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         st_q     <= 1'b0;
         st_dly_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         s1_q     <= btn_i;
         s2_q     <= s1_q;
         st_q     <= st_d;
         st_dly_q <= st_q;
         cnt_q    <= cnt_d;
      end
   end

   assign press_o = st_q & ~st_dly_q;
endmodule

module jk_cmd_debounce #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic set_btn,
   input  logic clr_btn,
   output logic j,
   output logic k,
   output logic cmd_valid
);
   localparam int NUM_BTN = 2;

   logic [NUM_BTN-1:0] btn;
   logic [NUM_BTN-1:0] press;
   logic               j_q, j_d;
   logic               k_q, k_d;
   logic               vld_q, vld_d;

   // Bit 1 drives J (set), bit 0 drives K (clear).
   assign btn = {set_btn, clr_btn};

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
      jk_cmd_debounce_lane #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_lane (
         .clk     (clk),
         .reset   (reset),
         .btn_i   (btn[g]),
         .press_o (press[g])
      );
   end

   always_comb begin
      j_d   = press[1];
      k_d   = press[0];
      vld_d = |press;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         j_q   <= 1'b0;
         k_q   <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         j_q   <= j_d;
         k_q   <= k_d;
         vld_q <= vld_d;
      end
   end

   assign j         = j_q;
   assign k         = k_q;
   assign cmd_valid = vld_q;
endmodule

// File: tb/tb_jk_cmd_debounce.sv
// Directed + random stimulus for jk_cmd_debounce, checked each cycle against a
// window-based model: st flips once the last DB sampled-and-synced values all differ from it.

module tb_jk_cmd_debounce;
   localparam int DB    = 4;
   localparam int CNT_W = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic set_btn = 1'b0;
   logic clr_btn = 1'b0;
   logic j, k, cmd_valid;

   jk_cmd_debounce #(.DB_CYCLES(DB), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .set_btn   (set_btn),
      .clr_btn   (clr_btn),
      .j         (j),
      .k         (k),
      .cmd_valid (cmd_valid)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Model state: raw samples since reset release, per button (index 1 = set, 0 = clr).
   bit raw_s[$];
   bit raw_c[$];
   bit st_m[2];
   bit press_prev[2];
   int ecnt = 0;
   bit exp_j = 0, exp_k = 0, exp_v = 0;

   // Pulse bookkeeping for directed checks.
   int cyc = 0;
   int jcnt = 0, kcnt = 0, both_cnt = 0;
   int jlast = 0, klast = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      assert (act === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   // Value s2 presents at edge e: the raw sample taken two edges earlier, 0 before that.
   function automatic bit s2v(input int b, input int e);
      if (e < 2) return 1'b0;
      return (b == 1) ? raw_s[e-2] : raw_c[e-2];
   endfunction

   task automatic model_clear();
      raw_s.delete();
      raw_c.delete();
      st_m[0] = 0; st_m[1] = 0;
      press_prev[0] = 0; press_prev[1] = 0;
      ecnt = 0;
      exp_j = 0; exp_k = 0; exp_v = 0;
   endtask

   task automatic step();
      bit press_now[2];
      bit flip;
      @(posedge clk);
      cyc++;
      if (!reset) begin
         raw_s.push_back(set_btn);
         raw_c.push_back(clr_btn);
         for (int b = 0; b < 2; b++) begin
            flip = 1'b1;
            for (int d = 0; d < DB; d++)
               if (s2v(b, ecnt - d) == st_m[b]) flip = 1'b0;
            press_now[b] = 1'b0;
            if (flip) begin
               st_m[b] = ~st_m[b];
               press_now[b] = st_m[b];
            end
         end
         exp_j = press_prev[1];
         exp_k = press_prev[0];
         exp_v = press_prev[1] | press_prev[0];
         press_prev = press_now;
         ecnt++;
      end else begin
         exp_j = 0; exp_k = 0; exp_v = 0;
      end
      #1;
      chk("j", j, exp_j);
      chk("k", k, exp_k);
      chk("cmd_valid", cmd_valid, exp_v);
      if (j === 1'b1) begin jcnt++; jlast = cyc; end
      if (k === 1'b1) begin kcnt++; klast = cyc; end
      if (j === 1'b1 && k === 1'b1) both_cnt++;
   endtask

   task automatic assert_reset();
      reset = 1'b1;
      model_clear();
      #1;
      chk("rst_j", j, 0);
      chk("rst_k", k, 0);
      chk("rst_vld", cmd_valid, 0);
   endtask

   task automatic release_reset();
      #2 reset = 1'b0;
   endtask

   int c0, jc0, kc0, bc0;

   initial begin
      // Reset asserted mid-cycle with both buttons pressed.
      model_clear();
      #12;
      set_btn = 1; clr_btn = 1;
      step();
      assert_reset();
      repeat (3) step();
      set_btn = 0; clr_btn = 0;
      step();
      release_reset();
      repeat (8) step();

      // Clean set press held 20 cycles, then released.
      set_btn = 1; c0 = cyc; jc0 = jcnt; kc0 = kcnt;
      repeat (20) step();
      set_btn = 0;
      repeat (12) step();
      chk("clean_jcnt", jcnt - jc0, 1);
      chk("clean_kcnt", kcnt - kc0, 0);
      chk("clean_lat", jlast - c0, DB + 3);

      // Bounce on clr, then stable hold.
      jc0 = jcnt; kc0 = kcnt;
      clr_btn = 1; step(); clr_btn = 0; step();
      clr_btn = 1; step(); clr_btn = 0; step();
      clr_btn = 1; c0 = cyc;
      repeat (15) step();
      chk("bounce_kcnt", kcnt - kc0, 1);
      chk("bounce_lat", klast - c0, DB + 3);
      clr_btn = 0;
      repeat (12) step();
      chk("bounce_rel_kcnt", kcnt - kc0, 1);

      // Short glitch shorter than the debounce window.
      jc0 = jcnt;
      set_btn = 1; repeat (DB - 1) step();
      set_btn = 0; repeat (12) step();
      chk("glitch_jcnt", jcnt - jc0, 0);

      // Simultaneous presses produce one toggle.
      jc0 = jcnt; kc0 = kcnt; bc0 = both_cnt;
      set_btn = 1; clr_btn = 1;
      repeat (12) step();
      chk("simul_both", both_cnt - bc0, 1);
      chk("simul_jcnt", jcnt - jc0, 1);
      set_btn = 0; clr_btn = 0;
      repeat (12) step();

      // Staggered presses stay separate.
      jc0 = jcnt; kc0 = kcnt; bc0 = both_cnt;
      set_btn = 1; step(); step();
      clr_btn = 1;
      repeat (14) step();
      chk("stag_both", both_cnt - bc0, 0);
      chk("stag_jcnt", jcnt - jc0, 1);
      chk("stag_kcnt", kcnt - kc0, 1);
      chk("stag_gap", klast - jlast, 2);
      set_btn = 0; clr_btn = 0;
      repeat (12) step();

      // Reset mid-debounce with the button still held afterwards.
      jc0 = jcnt;
      set_btn = 1; step(); step();
      assert_reset();
      step(); step();
      release_reset();
      c0 = cyc;
      repeat (14) step();
      chk("rstdb_jcnt", jcnt - jc0, 1);
      chk("rstdb_lat", jlast - c0, DB + 3);
      set_btn = 0;
      repeat (12) step();

      // Random segments with occasional resets.
      for (int seg = 0; seg < 120; seg++) begin
         set_btn = 1'($urandom);
         clr_btn = 1'($urandom);
         if ($urandom_range(0, 24) == 0) begin
            assert_reset();
            step();
            release_reset();
         end
         repeat ($urandom_range(1, 8)) step();
      end
      set_btn = 0; clr_btn = 0;
      repeat (12) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
